sp_ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for a single-port RAM instance (`xpm_memory_spram`-style: one address port, `ena`/`wea`/`regcea`, fixed read latency). It sits directly in front of the RAM, grants one read or write per cycle, registers the RAM command, and routes read data back to the issuing requester after the fixed RAM latency. It also owns a clear sequencer that fills the whole memory with a constant after reset or on command.

---
 rtl/sp_ram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sp_ram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - round-robin arbiter and clear sequencer in front of a single-port RAM
// Two requesters share one RAM port; read data is routed back via a latency-matched tag pipeline.
module sp_ram_arbiter #(
  parameter int              AW             = 3,
  parameter int              DW             = 4,
  parameter int              READ_LATENCY   = 3,
  parameter logic [DW-1:0]   INIT_VALUE     = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input  logic              clka,
  input  logic              rsta_n,
  input  logic              clear_start,
  output logic              busy,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*DW-1:0]   req_wdata,
  output logic [1:0]        rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              ram_rst,
  output logic              ram_ena,
  output logic              ram_wea,
  output logic              ram_regcea,
  output logic [AW-1:0]     ram_addra,
  output logic [DW-1:0]     ram_dina,
  input  logic [DW-1:0]     ram_douta
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t            state;
  state_t            state_next;
  logic [AW-1:0]     clr_cnt;
  logic [AW-1:0]     clr_cnt_next;
  logic              last_grant;
  logic              last_grant_next;
  logic [1:0]        grant;

  logic              sel;
  logic              sel_we;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;

  // Requester id of the command currently on the ram_* outputs.
  logic              cmd_id;

  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_id;

  always_comb begin
    state_next      = state;
    clr_cnt_next    = clr_cnt;
    last_grant_next = last_grant;
    grant           = 2'b00;
    case (state)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // On conflict the requester that did not win most recently goes first.
        if (req_valid == 2'b11) begin
          grant = last_grant ? 2'b01 : 2'b10;
        end else begin
          grant = req_valid;
        end
        if (grant[0]) begin
          last_grant_next = 1'b0;
        end else if (grant[1]) begin
          last_grant_next = 1'b1;
        end
        if (clear_start) begin
          state_next = ST_CLEAR;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  assign sel       = grant[1];
  assign sel_we    = sel ? req_we[1] : req_we[0];
  assign sel_addr  = sel ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign sel_wdata = sel ? req_wdata[DW +: DW] : req_wdata[0 +: DW];

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt    <= '0;
      last_grant <= 1'b1;
      ram_ena    <= 1'b0;
      ram_wea    <= 1'b0;
      ram_addra  <= '0;
      ram_dina   <= '0;
      cmd_id     <= 1'b0;
      tag_valid  <= '0;
      tag_id     <= '0;
    end else begin
      state      <= state_next;
      clr_cnt    <= clr_cnt_next;
      last_grant <= last_grant_next;
      ram_ena    <= 1'b0;
      ram_wea    <= 1'b0;
      if (state == ST_CLEAR) begin
        ram_ena   <= 1'b1;
        ram_wea   <= 1'b1;
        ram_addra <= clr_cnt;
        ram_dina  <= INIT_VALUE;
        cmd_id    <= 1'b0;
      end else if (grant != 2'b00) begin
        ram_ena   <= 1'b1;
        ram_wea   <= sel_we;
        ram_addra <= sel_addr;
        ram_dina  <= sel_wdata;
        cmd_id    <= sel;
      end
      // Tags advance every cycle so they line up with the RAM's fixed latency.
      tag_valid[0] <= ram_ena & ~ram_wea;
      tag_id[0]    <= cmd_id;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  assign busy       = (state == ST_CLEAR);
  assign req_ready  = grant;
  assign ram_rst    = ~rsta_n;
  assign ram_regcea = 1'b1;
  assign rsp_rdata  = ram_douta;
  assign rsp_valid  = tag_valid[READ_LATENCY-1]
                      ? (tag_id[READ_LATENCY-1] ? 2'b10 : 2'b01)
                      : 2'b00;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - randomized self-checking bench for sp_ram_arbiter
// A RAM model with fixed latency sits behind the DUT; expectations come from a shadow memory and response queue.
module tb_sp_ram_arbiter;
  localparam int AW    = 3;
  localparam int DW    = 4;
  localparam int RL    = 3;
  localparam int DEPTH = 8;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic              rsta_n;
  logic              clear_start;
  logic              busy;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [2*AW-1:0]   req_addr;
  logic [2*DW-1:0]   req_wdata;
  logic [1:0]        rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              ram_rst;
  logic              ram_ena;
  logic              ram_wea;
  logic              ram_regcea;
  logic [AW-1:0]     ram_addra;
  logic [DW-1:0]     ram_dina;
  logic [DW-1:0]     ram_douta;

  sp_ram_arbiter #(
    .AW(AW), .DW(DW), .READ_LATENCY(RL), .INIT_VALUE('0), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clka(clka), .rsta_n(rsta_n), .clear_start(clear_start), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_rst(ram_rst), .ram_ena(ram_ena), .ram_wea(ram_wea), .ram_regcea(ram_regcea),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_douta(ram_douta)
  );

  // Single-port RAM with READ_LATENCY output stages; seeded with garbage so the clear matters.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_pipe [RL];
  logic          seeded = 1'b0;
  always @(posedge clka) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom_range(1, 15));
      seeded <= 1'b1;
    end else if (ram_ena && ram_wea) begin
      mem[ram_addra] <= ram_dina;
    end
    rd_pipe[0] <= (ram_ena && !ram_wea) ? mem[ram_addra] : '0;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_douta = rd_pipe[RL-1];

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] shadow [DEPTH];
  int            cyc        = 0;
  int            clear_left = 0;
  logic          last       = 1'b1;
  int            checks     = 0;
  int            errors     = 0;

  function automatic logic [1:0] model_grant();
    if (!rsta_n || clear_left > 0) return 2'b00;
    if (req_valid == 2'b11) return last ? 2'b01 : 2'b10;
    return req_valid;
  endfunction

  function automatic logic [1:0] exp_rv();
    if (q.size() > 0 && q[0].due == cyc) return q[0].id ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] exp_rd();
    if (q.size() > 0) return q[0].data;
    return '0;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic cs);
    req_valid   = v;
    req_we      = we;
    req_addr    = {a1, a0};
    req_wdata   = {d1, d0};
    clear_start = cs;
  endtask

  // Applies this cycle's inputs to the reference model, then steps one clock.
  task automatic advance();
    logic [1:0]    g;
    logic          id;
    logic [AW-1:0] a;
    g = model_grant();
    if (!rsta_n) begin
      q.delete();
      clear_left = DEPTH;
      last = 1'b1;
      for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (g != 2'b00) begin
        id   = g[1];
        last = id;
        a    = id ? req_addr[AW +: AW] : req_addr[0 +: AW];
        if (req_we[id]) shadow[a] = id ? req_wdata[DW +: DW] : req_wdata[0 +: DW];
        else q.push_back('{cyc + 1 + RL, id, shadow[a]});
      end
      if (clear_start) begin
        clear_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
      end
    end
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    @(posedge clka);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rsta_n = 1'b0;
    drive(2'b11, 2'b00, '0, '0, '0, '0, 1'b1);
    advance();
    @(negedge clka);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", busy); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", req_ready); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    checks++; if ({ram_ena, ram_wea, ram_regcea, ram_rst} !== 4'b0011) begin
      errors++; $display("FAIL reset_ram_ctl got %b exp 0011", {ram_ena, ram_wea, ram_regcea, ram_rst});
    end
    checks++; if ({ram_addra, ram_dina} !== '0) begin
      errors++; $display("FAIL reset_ram_addr_data got %h/%h exp 0/0", ram_addra, ram_dina);
    end
    advance();
    rsta_n = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      if (k == DEPTH) drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      checks++; if (busy !== (k < DEPTH)) begin errors++; $display("FAIL clear_busy k=%0d got %b exp %b", k, busy, k < DEPTH); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL clear_ready k=%0d got %b exp 00", k, req_ready); end
      if (k > 0) begin
        checks++;
        if ({ram_ena, ram_wea, ram_addra, ram_dina} !== {2'b11, AW'(k - 1), DW'(0)}) begin
          errors++; $display("FAIL clear_write k=%0d got ena=%b we=%b a=%0d d=%h exp a=%0d d=0",
                             k, ram_ena, ram_wea, ram_addra, ram_dina, k - 1);
        end
      end
      advance();
    end
    for (int k = 0; k < DEPTH + RL + 1; k++) begin
      if (k < DEPTH) drive(2'b01, 2'b00, AW'(k), '0, '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      checks++; if (req_ready !== model_grant()) begin errors++; $display("FAIL init_read_ready k=%0d got %b exp %b", k, req_ready, model_grant()); end
      if (k >= RL + 1) begin
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 4'h0) begin
          errors++; $display("FAIL init_read_rsp k=%0d got %b/%h exp 01/0", k, rsp_valid, rsp_rdata);
        end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL init_read_idle k=%0d got %b exp 00", k, rsp_valid); end
      end
      advance();
    end
  endtask

  task automatic test_read_after_write();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) drive(2'b01, 2'b01, 3'd5, '0, 4'hA, '0, 1'b0);
      else if (k == 1) drive(2'b01, 2'b00, 3'd5, '0, '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      if (k < 2) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL raw_ready k=%0d got %b exp 01", k, req_ready); end
      end
      if (k == 5) begin
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== 4'hA) begin
          errors++; $display("FAIL raw_rsp got %b/%h exp 01/a", rsp_valid, rsp_rdata);
        end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL raw_idle k=%0d got %b exp 00", k, rsp_valid); end
      end
      advance();
    end
  endtask

  task automatic test_alternate();
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic [1:0]    prev;
    d1 = DW'($urandom);
    d2 = DW'($urandom);
    prev = 2'b00;
    for (int k = 0; k < 16; k++) begin
      if (k == 0) drive(2'b01, 2'b01, 3'd1, '0, d1, '0, 1'b0);
      else if (k == 1) drive(2'b10, 2'b10, '0, 3'd2, '0, d2, 1'b0);
      else if (k < 12) drive(2'b11, 2'b00, 3'd1, 3'd2, '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      checks++; if (req_ready !== model_grant()) begin errors++; $display("FAIL alt_ready k=%0d got %b exp %b", k, req_ready, model_grant()); end
      checks++; if (req_ready == 2'b11) begin errors++; $display("FAIL alt_onehot k=%0d got %b exp at most one bit", k, req_ready); end
      if (k > 2 && k < 12) begin
        checks++; if (req_ready !== ~prev) begin errors++; $display("FAIL alt_toggle k=%0d got %b exp %b", k, req_ready, ~prev); end
      end
      checks++; if (rsp_valid !== exp_rv()) begin errors++; $display("FAIL alt_rsp_valid k=%0d got %b exp %b", k, rsp_valid, exp_rv()); end
      if (rsp_valid == 2'b01) begin
        checks++; if (rsp_rdata !== d1) begin errors++; $display("FAIL alt_rdata0 k=%0d got %h exp %h", k, rsp_rdata, d1); end
      end else if (rsp_valid == 2'b10) begin
        checks++; if (rsp_rdata !== d2) begin errors++; $display("FAIL alt_rdata1 k=%0d got %h exp %h", k, rsp_rdata, d2); end
      end
      prev = req_ready;
      advance();
    end
  endtask

  task automatic test_req1_burst();
    for (int k = 0; k < 9; k++) begin
      if (k < 3) drive(2'b10, 2'b00, '0, AW'($urandom), '0, '0, 1'b0);
      else if (k == 3) drive(2'b11, 2'b00, AW'($urandom), AW'($urandom), '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      if (k == 3) begin
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL burst_conflict got %b exp 01", req_ready); end
      end else begin
        checks++; if (req_ready !== model_grant()) begin errors++; $display("FAIL burst_ready k=%0d got %b exp %b", k, req_ready, model_grant()); end
      end
      if (k >= 4 && k <= 6) begin
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL burst_rsp k=%0d got %b exp 10", k, rsp_valid); end
      end
      checks++; if (rsp_valid !== exp_rv()) begin errors++; $display("FAIL burst_rsp_model k=%0d got %b exp %b", k, rsp_valid, exp_rv()); end
      if (exp_rv() != 2'b00) begin
        checks++; if (rsp_rdata !== exp_rd()) begin errors++; $display("FAIL burst_rdata k=%0d got %h exp %h", k, rsp_rdata, exp_rd()); end
      end
      advance();
    end
  endtask

  task automatic test_clear_inflight();
    logic [DW-1:0] pre;
    drive(2'b01, 2'b01, 3'd3, '0, 4'h7, '0, 1'b0);
    advance();
    pre = shadow[3];
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) drive(2'b01, 2'b00, 3'd3, '0, '0, '0, 1'b0);
      else if (k == 1) drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b1);
      else if (k < 10) drive(2'b11, 2'b00, AW'($urandom), AW'($urandom), '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      checks++; if (busy !== (k >= 2 && k <= 9)) begin errors++; $display("FAIL clr_busy k=%0d got %b exp %b", k, busy, k >= 2 && k <= 9); end
      if (k >= 2) begin
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL clr_ready k=%0d got %b exp 00", k, req_ready); end
      end
      if (k == 4) begin
        checks++;
        if (rsp_valid !== 2'b01 || rsp_rdata !== pre) begin
          errors++; $display("FAIL clr_inflight_rsp got %b/%h exp 01/%h", rsp_valid, rsp_rdata, pre);
        end
      end else begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL clr_idle k=%0d got %b exp 00", k, rsp_valid); end
      end
      advance();
    end
  endtask

  task automatic test_reset_midop();
    for (int k = 0; k <= 11; k++) begin
      rsta_n = (k != 2);
      if (k == 0) drive(2'b01, 2'b00, AW'($urandom), '0, '0, '0, 1'b0);
      else if (k == 1) drive(2'b10, 2'b00, '0, AW'($urandom), '0, '0, 1'b0);
      else if (k >= 3 && k <= 10) drive(2'b11, 2'b00, AW'($urandom), AW'($urandom), '0, '0, 1'b0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      if (k >= 2) begin
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midrst_rsp k=%0d got %b exp 00", k, rsp_valid); end
      end
      if (k == 3) begin
        checks++;
        if ({busy, req_ready, ram_ena, ram_wea, ram_regcea, ram_addra, ram_dina} !== {1'b1, 2'b00, 3'b001, AW'(0), DW'(0)}) begin
          errors++; $display("FAIL midrst_outputs got busy=%b rdy=%b ena=%b we=%b a=%0d d=%h exp 1/00/0/0/0/0",
                             busy, req_ready, ram_ena, ram_wea, ram_addra, ram_dina);
        end
      end
      if (k >= 4) begin
        checks++;
        if ({ram_ena, ram_wea, ram_addra} !== {2'b11, AW'(k - 4)}) begin
          errors++; $display("FAIL midrst_clear k=%0d got ena=%b we=%b a=%0d exp a=%0d", k, ram_ena, ram_wea, ram_addra, k - 4);
        end
      end
      advance();
    end
    rsta_n = 1'b1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400 + RL + 2; k++) begin
      if (k < 400) drive(2'($urandom), 2'($urandom), AW'($urandom), AW'($urandom),
                         DW'($urandom), DW'($urandom), $urandom_range(0, 49) == 0);
      else drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
      @(negedge clka);
      checks++; if (req_ready !== model_grant()) begin errors++; $display("FAIL rnd_ready cyc=%0d got %b exp %b", cyc, req_ready, model_grant()); end
      checks++; if (busy !== (clear_left > 0)) begin errors++; $display("FAIL rnd_busy cyc=%0d got %b exp %b", cyc, busy, clear_left > 0); end
      checks++; if (rsp_valid !== exp_rv()) begin errors++; $display("FAIL rnd_rsp_valid cyc=%0d got %b exp %b", cyc, rsp_valid, exp_rv()); end
      if (exp_rv() != 2'b00) begin
        checks++; if (rsp_rdata !== exp_rd()) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, rsp_rdata, exp_rd()); end
      end
      advance();
    end
  endtask

  initial begin
    rsta_n = 1'b0;
    drive(2'b00, 2'b00, '0, '0, '0, '0, 1'b0);
    test_reset();
    test_read_after_write();
    test_alternate();
    test_req1_burst();
    test_clear_inflight();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
